// File: rtl/fixed_p_std_div_pipe.sv
// fixed_p_std_div_pipe
// Multi-cycle unsigned fixed-point divider in Q(INT_WIDTH.FRACT_WIDTH) format.
// Restoring division on the scaled dividend (left << FRACT_WIDTH), one quotient
// bit per cycle, started by a go/done handshake.
//
// Optional build macro: FIXED_P_DIV_SATURATE_EN
//   defined   -> quotient saturates to all ones when it does not fit in WIDTH bits
//   undefined -> quotient is truncated to its low WIDTH bits
// Divide-by-zero always returns an all-ones quotient and remainder = left.
//
// done and the result registers are written on the edge that leaves DONE, so
// done is a registered one-cycle pulse and results stay put until the next one.

module fixed_p_std_div_pipe #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned INT_WIDTH   = 8,
  parameter int unsigned FRACT_WIDTH = 24
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             go,
  input  logic [WIDTH-1:0] left,
  input  logic [WIDTH-1:0] right,
  output logic [WIDTH-1:0] out_quotient,
  output logic [WIDTH-1:0] out_remainder,
  output logic             done
);

  // Scaled dividend width and iteration counter width
  localparam int unsigned N  = WIDTH + FRACT_WIDTH;
  localparam int unsigned CW = $clog2(N + 1);

  // The Q format only makes sense when the integer and fraction fields fill WIDTH
  if (WIDTH != INT_WIDTH + FRACT_WIDTH) begin : g_bad_width
    $error("fixed_p_std_div_pipe: WIDTH must equal INT_WIDTH + FRACT_WIDTH");
  end

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e          state_q;
  logic [N-1:0]    dividend_q;
  logic [WIDTH:0]  rem_q;
  logic [N-1:0]    quo_q;
  logic [WIDTH-1:0] divisor_q;
  logic [CW-1:0]   count_q;

  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   rem_step;
  logic             fits;
  logic [WIDTH-1:0] quo_final;

  // The top remainder bit is always clear after a step, and the high quotient
  // bits only matter when saturation is built in.
  logic unused_bits;
  assign unused_bits = ^{rem_q[WIDTH], quo_q[N-1:WIDTH]};

  // One restoring step: bring in the next dividend bit, subtract if it fits
  always_comb begin
    rem_shift = {rem_q[WIDTH-1:0], dividend_q[N-1]};
    fits      = (rem_shift >= {1'b0, divisor_q});
    rem_step  = rem_shift;
    if (fits) begin
      rem_step = rem_shift - {1'b0, divisor_q};
    end
  end

  // Fold the full N-bit quotient down to the WIDTH-bit result
  always_comb begin
`ifdef FIXED_P_DIV_SATURATE_EN
    quo_final = quo_q[WIDTH-1:0];
    if (|quo_q[N-1:WIDTH]) begin
      quo_final = '1;
    end
`else
    quo_final = quo_q[WIDTH-1:0];
`endif
  end

  // Control FSM, datapath registers and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      dividend_q    <= '0;
      rem_q         <= '0;
      quo_q         <= '0;
      divisor_q     <= '0;
      count_q       <= '0;
      out_quotient  <= '0;
      out_remainder <= '0;
      done          <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (go) begin
            divisor_q <= right;
            if (right != '0) begin
              dividend_q <= {left, {FRACT_WIDTH{1'b0}}};
              rem_q      <= '0;
              quo_q      <= '0;
              count_q    <= CW'(N);
              state_q    <= StRun;
            end else begin
              // Divide-by-zero skips the iterations entirely
              dividend_q <= '0;
              rem_q      <= {1'b0, left};
              quo_q      <= '1;
              count_q    <= '0;
              state_q    <= StDone;
            end
          end
        end
        StRun: begin
          dividend_q <= dividend_q << 1;
          rem_q      <= rem_step;
          quo_q      <= {quo_q[N-2:0], fits};
          count_q    <= count_q - CW'(1);
          if (count_q == CW'(1)) begin
            state_q <= StDone;
          end
        end
        StDone: begin
          out_quotient  <= quo_final;
          out_remainder <= rem_q[WIDTH-1:0];
          done          <= 1'b1;
          state_q       <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fixed_p_std_div_pipe.sv
// Self-checking bench for fixed_p_std_div_pipe in a small Q4.4 configuration.
// Expected results come from plain integer arithmetic on the scaled dividend.

module tb_fixed_p_std_div_pipe;

  localparam int unsigned W  = 8;
  localparam int unsigned IW = 4;
  localparam int unsigned FW = 4;
  localparam int LatRun  = 13;  // N + 1 edges after the go sample
  localparam int LatZero = 1;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         go = 1'b0;
  logic [W-1:0] left = '0;
  logic [W-1:0] right = '0;
  logic [W-1:0] out_quotient;
  logic [W-1:0] out_remainder;
  logic         done;

  int errors = 0;
  int checks = 0;

  fixed_p_std_div_pipe #(
    .WIDTH      (W),
    .INT_WIDTH  (IW),
    .FRACT_WIDTH(FW)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .go           (go),
    .left         (left),
    .right        (right),
    .out_quotient (out_quotient),
    .out_remainder(out_remainder),
    .done         (done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: Q/R of (left * 2^FW) / right as integers
  function automatic void model(input logic [W-1:0] l, input logic [W-1:0] r,
                                output logic [W-1:0] q, output logic [W-1:0] rm);
    longint unsigned dd, qf, rf;
    if (r == '0) begin
      q  = '1;
      rm = l;
      return;
    end
    dd = longint'(l) * (longint'(1) << FW);
    qf = dd / longint'(r);
    rf = dd % longint'(r);
    q  = qf[W-1:0];
`ifdef FIXED_P_DIV_SATURATE_EN
    if (qf >= (longint'(1) << W)) q = '1;
`endif
    rm = rf[W-1:0];
  endfunction

  // Count edges after the current one until done shows up (bounded)
  task automatic wait_done(input bit scramble, output int n);
    n = 0;
    while (!done && n < 40) begin
      if (scramble) begin
        left  = W'($urandom);
        right = W'($urandom);
        go    = 1'($urandom);
      end
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  // Called #1 after a rising edge; drives one operation and checks it
  task automatic run_op(input string tag, input logic [W-1:0] l, input logic [W-1:0] r,
                        input bit scramble);
    logic [W-1:0] eq, er;
    int n;
    model(l, r, eq, er);
    left  = l;
    right = r;
    go    = 1'b1;
    @(posedge clk);
    #1;
    go = 1'b0;
    wait_done(scramble, n);
    go = 1'b0;
    check_eq({tag, "_latency"}, 32'(n), (r == '0) ? 32'(LatZero) : 32'(LatRun));
    check_eq({tag, "_quotient"}, 32'(out_quotient), 32'(eq));
    check_eq({tag, "_remainder"}, 32'(out_remainder), 32'(er));
    @(posedge clk);
    #1;
    check_eq({tag, "_done_pulse"}, 32'(done), 32'(0));
    check_eq({tag, "_hold"}, 32'(out_quotient), 32'(eq));
  endtask

  initial begin
    int n;
    logic [W-1:0] rl, rr;

    // Reset state
    #3;
    check_eq("reset_quotient", 32'(out_quotient), 32'(0));
    check_eq("reset_remainder", 32'(out_remainder), 32'(0));
    check_eq("reset_done", 32'(done), 32'(0));
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed cases
    run_op("div_3_2", 8'h30, 8'h20, 1'b0);
    check_eq("div_3_2_const", 32'(out_quotient), 32'h18);
    run_op("div_1_3", 8'h10, 8'h30, 1'b1);
    check_eq("div_1_3_const_q", 32'(out_quotient), 32'h05);
    check_eq("div_1_3_const_r", 32'(out_remainder), 32'h10);
    run_op("overflow", 8'hF0, 8'h01, 1'b0);
`ifdef FIXED_P_DIV_SATURATE_EN
    check_eq("overflow_const", 32'(out_quotient), 32'hFF);
`else
    check_eq("overflow_const", 32'(out_quotient), 32'h00);
`endif
    run_op("div_zero", 8'h37, 8'h00, 1'b0);
    check_eq("div_zero_const_q", 32'(out_quotient), 32'hFF);
    check_eq("div_zero_const_r", 32'(out_remainder), 32'h37);

    // Reset in the middle of an operation
    left  = 8'h30;
    right = 8'h20;
    go    = 1'b1;
    @(posedge clk);
    #1;
    go = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check_eq("midreset_quotient", 32'(out_quotient), 32'(0));
    check_eq("midreset_remainder", 32'(out_remainder), 32'(0));
    check_eq("midreset_done", 32'(done), 32'(0));
    repeat (3) @(posedge clk);
    #1;
    check_eq("midreset_no_done", 32'(done), 32'(0));
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    run_op("after_reset", 8'h10, 8'h30, 1'b0);

    // Back-to-back with go held high
    left  = 8'h30;
    right = 8'h20;
    go    = 1'b1;
    @(posedge clk);
    #1;
    wait_done(1'b0, n);
    check_eq("b2b_first_latency", 32'(n), 32'(LatRun));
    check_eq("b2b_first_quotient", 32'(out_quotient), 32'h18);
    check_eq("b2b_first_remainder", 32'(out_remainder), 32'h00);
    left  = 8'h10;
    right = 8'h30;
    n = 0;
    while ((n == 0 || !done) && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 7) check_eq("b2b_held_quotient", 32'(out_quotient), 32'h18);
    end
    go = 1'b0;
    check_eq("b2b_spacing", 32'(n), 32'd14);
    check_eq("b2b_second_quotient", 32'(out_quotient), 32'h05);
    check_eq("b2b_second_remainder", 32'(out_remainder), 32'h10);
    @(posedge clk);
    #1;
    check_eq("b2b_done_pulse", 32'(done), 32'(0));

    // Randomised operations, including tiny divisors and divide-by-zero
    for (int i = 0; i < 40; i++) begin
      rl = W'($urandom);
      case ($urandom_range(0, 3))
        0:       rr = '0;
        1:       rr = W'($urandom_range(1, 15));
        default: rr = W'($urandom);
      endcase
      run_op("random", rl, rr, 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
